// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port and
// a per-register busy scoreboard used by decode for RAW/WAW hazard detection.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic [AW:0]     busy_cnt
);

    localparam logic [AW:0] NR = NREGS[AW:0];

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_cnt;

    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;
    logic             w_rs1_vld, w_rs2_vld, w_wr_vld, w_iss_vld;
    logic             w_rs1_fwd, w_rs2_fwd;

    function automatic logic addr_vld(input logic [AW-1:0] a);
        return ({1'b0, a} < NR) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_rs1_vld = addr_vld(rs1_addr);
    assign w_rs2_vld = addr_vld(rs2_addr);
    assign w_wr_vld  = addr_vld(wr_addr);
    assign w_iss_vld = addr_vld(iss_rd);

    // Forwarding only ever applies to valid read addresses; invalid ones read 0.
    assign w_rs1_fwd = (BYPASS != 0) && wr_en && (wr_addr == rs1_addr);
    assign w_rs2_fwd = (BYPASS != 0) && wr_en && (wr_addr == rs2_addr);

    assign rs1_data = !w_rs1_vld ? '0 : (w_rs1_fwd ? wr_data : r_regs[rs1_addr]);
    assign rs2_data = !w_rs2_vld ? '0 : (w_rs2_fwd ? wr_data : r_regs[rs2_addr]);

    assign rs1_busy = w_rs1_vld && r_busy[rs1_addr] && !w_rs1_fwd;
    assign rs2_busy = w_rs2_vld && r_busy[rs2_addr] && !w_rs2_fwd;
    assign rd_busy  = iss_en && w_iss_vld && r_busy[iss_rd];
    assign busy_cnt = r_cnt;

    // Flush beats issue, issue beats writeback clear (new producer after old one).
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (flush)
                w_busy_nxt[r] = 1'b0;
            else if (iss_en && w_iss_vld && (iss_rd == AW'(r)))
                w_busy_nxt[r] = 1'b1;
            else if (wr_en && (wr_addr == AW'(r)))
                w_busy_nxt[r] = 1'b0;
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                r_regs[r] <= '0;
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (wr_en && w_wr_vld)
                r_regs[wr_addr] <= wr_data;
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing instance and a non-bypassing
// instance share all inputs so forwarding differences are visible side by side.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic [31:0] wr_data;
    logic        wr_en, iss_en, flush;

    logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
    logic        rs1_busy, rs2_busy, rd_busy, nb_rs1_busy, nb_rs2_busy, nb_rd_busy;
    logic [5:0]  busy_cnt, nb_busy_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
        .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy), .rd_busy(nb_rd_busy),
        .busy_cnt(nb_busy_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; idle(); rs1_addr = 5'd5; rs2_addr = 5'd0; wr_addr = 0; wr_data = 0; iss_rd = 0;
        #3;
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", busy_cnt); end
        checks++; if (rs1_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", rs1_data); end
        tick(); rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678; iss_en = 1'b1; iss_rd = 5'd5;
        tick(); idle();
        #1;
        checks++; if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL x5_write got %h want 12345678", rs1_data); end
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL x5_busy_cnt got %0d want 1", busy_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rs1_data !== 32'd0) begin errors++; $display("FAIL async_rst_data got %h want 0", rs1_data); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL async_rst_cnt got %0d want 0", busy_cnt); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", rs1_busy); end
        tick(); rst = 1'b0;
    endtask

    task automatic test_zero_reg;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
        #1;
        checks++; if (rs1_data !== 32'd0) begin errors++; $display("FAIL x0_fwd got %h want 0", rs1_data); end
        checks++; if (rd_busy !== 1'b0) begin errors++; $display("FAIL x0_rd_busy got %b want 0", rd_busy); end
        tick(); idle();
        #1;
        checks++; if (rs1_data !== 32'd0) begin errors++; $display("FAIL x0_read got %h want 0", rs1_data); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got %b want 0", rs1_busy); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL x0_cnt got %0d want 0", busy_cnt); end
    endtask

    task automatic test_bypass;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA;
        tick();
        wr_data = 32'hB; rs2_addr = 5'd7;
        #1;
        checks++; if (rs2_data !== 32'hB) begin errors++; $display("FAIL bypass_fwd got %h want b", rs2_data); end
        checks++; if (nb_rs2_data !== 32'hA) begin errors++; $display("FAIL nobypass_old got %h want a", nb_rs2_data); end
        checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL bypass_busy got %b want 0", rs2_busy); end
        tick(); idle();
        #1;
        checks++; if (rs2_data !== 32'hB) begin errors++; $display("FAIL bypass_after got %h want b", rs2_data); end
        checks++; if (nb_rs2_data !== 32'hB) begin errors++; $display("FAIL nobypass_after got %h want b", nb_rs2_data); end
    endtask

    task automatic test_scoreboard;
        iss_en = 1'b1; iss_rd = 5'd3;
        tick(); idle(); rs1_addr = 5'd3;
        #1;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy got %b want 1", rs1_busy); end
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt got %0d want 1", busy_cnt); end
        tick(); tick(); tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_wb_bypass got %b want 0", rs1_busy); end
        checks++; if (nb_rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_wb_nobypass got %b want 1", nb_rs1_busy); end
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_wb_cnt got %0d want 1", busy_cnt); end
        tick(); idle();
        #1;
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL sb_after_cnt got %0d want 0", busy_cnt); end
        checks++; if (nb_rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_after_nb got %b want 0", nb_rs1_busy); end
        checks++; if (rs1_data !== 32'h33) begin errors++; $display("FAIL sb_after_data got %h want 33", rs1_data); end
    endtask

    task automatic test_same_cycle;
        iss_en = 1'b1; iss_rd = 5'd9;
        #1;
        checks++; if (rd_busy !== 1'b0) begin errors++; $display("FAIL waw_first got %b want 0", rd_busy); end
        tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        #1;
        checks++; if (rd_busy !== 1'b1) begin errors++; $display("FAIL waw_setclr got %b want 1", rd_busy); end
        tick(); idle(); rs1_addr = 5'd9;
        #1;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL setclr_busy got %b want 1", rs1_busy); end
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL setclr_cnt got %0d want 1", busy_cnt); end
        iss_en = 1'b1; iss_rd = 5'd9;
        #1;
        checks++; if (rd_busy !== 1'b1) begin errors++; $display("FAIL waw_again got %b want 1", rd_busy); end
        tick(); idle();
        #1;
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL waw_cnt got %0d want 1", busy_cnt); end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
        tick(); idle();
        #1;
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL x9_clear_cnt got %0d want 0", busy_cnt); end
    endtask

    task automatic test_flush;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
        tick(); idle();
        iss_en = 1'b1; iss_rd = 5'd1; tick();
        iss_rd = 5'd2; tick();
        iss_rd = 5'd4; tick(); idle();
        #1;
        checks++; if (busy_cnt !== 6'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d want 3", busy_cnt); end
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd6;
        tick(); idle(); rs1_addr = 5'd6; rs2_addr = 5'd2;
        #1;
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt got %0d want 0", busy_cnt); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL flush_x6 got %b want 0", rs1_busy); end
        checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL flush_x2 got %b want 0", rs2_busy); end
        checks++; if (rs2_data !== 32'h22) begin errors++; $display("FAIL flush_data got %h want 22", rs2_data); end
        rs1_addr = 5'd7;
        #1;
        checks++; if (rs1_data !== 32'hB) begin errors++; $display("FAIL flush_x7 got %h want b", rs1_data); end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_same_cycle();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the RV32I core pipeline: two combinational read ports, one synchronous write port, optional write-through bypass, optional hardwired zero register.
- Adds an asynchronous clear of all registers and a per-register scoreboard of busy bits.
- The scoreboard tracks destinations issued but not yet written back, so decode can detect RAW hazards and stall.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..2**AW)
AW, 5, register address width
BYPASS, 1, 1 = same-cycle write data forwarded to read ports and busy outputs
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and issues

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
wr_en  input  1  writeback enable
wr_addr  input  AW  writeback destination
wr_data  input  XLEN  writeback data
iss_en  input  1  instruction issued with a destination; mark it busy
iss_rd  input  AW  destination of issued instruction
flush  input  1  synchronous clear of all busy bits (pipeline flush)
rs1_busy  output  1  rs1_addr has a pending write not yet available
rs2_busy  output  1  rs2_addr has a pending write not yet available
rd_busy  output  1  iss_rd already busy (WAW indication)
busy_cnt  output  AW+1  number of busy registers, registered

Behaviour:
- Reset: async on rst high; all NREGS registers = 0, all busy bits = 0, busy_cnt = 0. Remains cleared while rst is high. Reset mid-operation discards pending writes and issues that cycle.
- "Valid address": addr < NREGS and not (ZERO_REG and addr == 0).
- Write: at posedge, if wr_en and wr_addr valid: reg[wr_addr] <= wr_data. Invalid address: no state change.
- Read, combinational, zero latency:
  - Invalid address -> 0.
  - Else if BYPASS and wr_en and wr_addr == addr -> wr_data.
  - Else reg[addr].
- Scoreboard next-state per register r, priority order:
  1. flush -> busy[r] = 0 (overrides iss_en and wr_en clears).
  2. iss_en and iss_rd == r and r valid -> busy[r] = 1.
  3. wr_en and wr_addr == r -> busy[r] = 0.
  4. Else hold.
  - Simultaneous wr_en and iss_en to the same register: set wins (new producer after old writeback).
- Write to a non-busy register is legal: data written, busy stays 0.
- iss_en to an already-busy register: stays busy; rd_busy = 1 that cycle.
- rsN_busy = busy[addrN] and addrN valid and not (BYPASS and wr_en and wr_addr == addrN). With BYPASS = 0, busy is reported until the cycle after writeback.
- rd_busy = iss_en and iss_rd valid and busy[iss_rd]. Combinational; the bypass term does not apply.
- busy_cnt updates on the same edge as the busy bits and always equals the popcount of the current busy vector (range 0..NREGS, no wrap).
- Register NREGS-1 and addresses >= NREGS (when NREGS < 2**AW) need no special wrap: out-of-range is treated as invalid.
- No read enable; read ports are always live.

Test Plan:
- Reset: write 0x1234_5678 to x5, assert rst asynchronously mid-cycle -> rs1_data for x5 = 0 immediately, busy_cnt = 0.
- Zero reg: wr_en, wr_addr = 0, wr_data = 0xFFFF_FFFF; iss_en, iss_rd = 0 -> rs1_addr = 0 reads 0, rs1_busy = 0, busy_cnt stays 0.
- Bypass: x7 = 0xA; in the same cycle wr_en to x7 with 0xB and rs2_addr = 7 -> rs2_data = 0xB combinationally, rs2_busy = 0; after the edge 0xB is read. With BYPASS = 0 -> rs2_data = 0xA that cycle.
- Scoreboard: iss x3 at cycle 0 -> cycle 1 rs1_addr = 3 gives rs1_busy = 1, busy_cnt = 1. Writeback x3 at cycle 4 -> rs1_busy = 0 in cycle 4 (bypass), busy_cnt = 0 at cycle 5.
- Same-cycle set/clear: x9 busy; wr_en x9 and iss_en x9 together -> x9 still busy next cycle, busy_cnt unchanged. iss_en x9 again -> rd_busy = 1.
- Flush: issue x1, x2, x4 (busy_cnt = 3); flush with iss_en x6 in the same cycle -> all busy = 0, busy_cnt = 0; register contents unchanged.
